// File: rtl/stream_demux_if.sv
// Handshake bundle between one beat source and the demux's NUM_OUT consumers.
// slave is the demux view; master is the source/consumer view.
interface stream_demux_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned SEL_W   = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic                in_last;
    logic [SEL_W-1:0]    in_sel;
    logic [NUM_OUT-1:0]  out_valid;
    logic [NUM_OUT-1:0]  out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;

    modport slave (
        input  in_valid, in_data, in_last, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT packet demultiplexer: the first beat's select locks the
// destination for the whole packet; out-of-range destinations are counted and dropped.
module stream_demux #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned SEL_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    stream_demux_if.slave       bus,
    output logic [7:0]          drop_cnt
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t              state;
    logic [SEL_W-1:0]    lock_sel;

    // Holding register; the one-hot valid vector encodes both hold_valid and hold_dst.
    logic [NUM_OUT-1:0]  hold_onehot;
    logic [DATA_W-1:0]   hold_data;
    logic                hold_last;
    logic [CNT_W-1:0]    drop_q;

    logic                hold_valid_c;
    logic                drain_c;
    logic                accept_c;
    logic [SEL_W-1:0]    dst_c;
    logic [NUM_OUT-1:0]  dst_onehot_c;
    logic                dst_ok_c;

    assign hold_valid_c = |hold_onehot;
    assign drain_c      = |(hold_onehot & bus.out_ready);
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign dst_c        = (state == IDLE) ? bus.in_sel : lock_sel;

    // Decode destination; an index with no matching port leaves the vector empty.
    always_comb begin
        dst_onehot_c = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            dst_onehot_c[i] = (dst_c == SEL_W'(i));
        end
    end

    assign dst_ok_c = |dst_onehot_c;

    // Only the addressed consumer's ready gates the input; no path from in_valid.
    assign bus.in_ready  = !hold_valid_c || drain_c;
    assign bus.out_valid = hold_onehot;
    assign bus.out_data  = hold_data;
    assign bus.out_last  = hold_last;
    assign drop_cnt      = drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lock_sel    <= '0;
            hold_onehot <= '0;
            hold_data   <= '0;
            hold_last   <= 1'b0;
            drop_q      <= '0;
        end else begin
            // Load wins over drain so a new beat can replace a draining one without a bubble.
            if (accept_c && dst_ok_c) begin
                hold_onehot <= dst_onehot_c;
                hold_data   <= bus.in_data;
                hold_last   <= bus.in_last;
            end else if (drain_c) begin
                hold_onehot <= '0;
            end

            if (accept_c && !dst_ok_c && (drop_q != {CNT_W{1'b1}})) begin
                drop_q <= drop_q + CNT_W'(1);
            end

            // Packet framing advances on every accepted beat, dropped ones included.
            if (accept_c) begin
                case (state)
                    IDLE: begin
                        if (!bus.in_last) begin
                            state    <= PKT;
                            lock_sel <= bus.in_sel;
                        end
                    end
                    PKT: begin
                        if (bus.in_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-port instance for delivery paths and a
// 3-port instance for the out-of-range drop and counter saturation paths.
module tb_stream_demux;
    logic clk;
    logic reset;
    logic [7:0] drop_a;
    logic [7:0] drop_b;
    int vectors;
    int errors;

    stream_demux_if #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) a_if ();
    stream_demux_if #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) b_if ();

    stream_demux #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) u_dut4 (
        .clk(clk), .reset(reset), .bus(a_if), .drop_cnt(drop_a)
    );
    stream_demux #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .bus(b_if), .drop_cnt(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
        a_if.in_valid = v; a_if.in_sel = s; a_if.in_data = d; a_if.in_last = l;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
        b_if.in_valid = v; b_if.in_sel = s; b_if.in_data = d; b_if.in_last = l;
    endtask

    task automatic test_reset();
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0000 || a_if.out_data !== 8'h00 || a_if.out_last !== 1'b0 || drop_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h last=%b drop=%0d expected 0000/00/0/0",
                     a_if.out_valid, a_if.out_data, a_if.out_last, drop_a);
        end
        reset = 1'b0;
        drive_a(1'b1, 2'd1, 8'hAA, 1'b1);
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0010) begin
            errors++;
            $display("FAIL pre_reset_load: valid=%b expected 0010", a_if.out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (a_if.out_valid !== 4'b0000 || drop_a !== 8'd0 || a_if.out_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: valid=%b drop=%0d data=%h expected 0000/0/00",
                     a_if.out_valid, drop_a, a_if.out_data);
        end
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: valid=%b expected 0000", a_if.out_valid);
        end
        reset = 1'b0;
        drive_a(1'b1, 2'd2, 8'h5A, 1'b1);
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0100 || a_if.out_data !== 8'h5A || a_if.out_last !== 1'b1) begin
            errors++;
            $display("FAIL first_packet: valid=%b data=%h last=%b expected 0100/5a/1",
                     a_if.out_valid, a_if.out_data, a_if.out_last);
        end
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL first_drain: valid=%b expected 0000", a_if.out_valid);
        end
    endtask

    task automatic test_packet_lock();
        logic [1:0] sels [3];
        logic [7:0] datas [3];
        sels[0] = 2'd1; sels[1] = 2'd3; sels[2] = 2'd3;
        datas[0] = 8'h10; datas[1] = 8'h11; datas[2] = 8'h12;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, sels[i], datas[i], (i == 2));
            cyc();
            vectors++;
            if (a_if.out_valid !== 4'b0010 || a_if.out_data !== datas[i] || a_if.out_last !== (i == 2)) begin
                errors++;
                $display("FAIL lock_beat%0d: valid=%b data=%h last=%b expected 0010/%h/%0d",
                         i, a_if.out_valid, a_if.out_data, a_if.out_last, datas[i], (i == 2));
            end
        end
        // A fresh packet must honour its own select, proving the lock released.
        drive_a(1'b1, 2'd0, 8'h20, 1'b1);
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0001 || a_if.out_data !== 8'h20) begin
            errors++;
            $display("FAIL lock_release: valid=%b data=%h expected 0001/20", a_if.out_valid, a_if.out_data);
        end
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();
    endtask

    task automatic test_back_pressure();
        a_if.out_ready = 4'b1110;
        drive_a(1'b1, 2'd0, 8'h30, 1'b0);
        cyc();
        drive_a(1'b1, 2'd2, 8'h31, 1'b1);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (a_if.out_valid !== 4'b0001 || a_if.out_data !== 8'h30 || a_if.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h in_ready=%b expected 0001/30/0",
                         k, a_if.out_valid, a_if.out_data, a_if.in_ready);
            end
            cyc();
        end
        a_if.out_ready = 4'b1111;
        #1;
        vectors++;
        if (a_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b expected 1", a_if.in_ready);
        end
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0001 || a_if.out_data !== 8'h31 || a_if.out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: valid=%b data=%h last=%b expected 0001/31/1",
                     a_if.out_valid, a_if.out_data, a_if.out_last);
        end
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bp_drain: valid=%b expected 0000", a_if.out_valid);
        end
    endtask

    task automatic test_stream_switch();
        drive_a(1'b1, 2'd3, 8'h41, 1'b1);
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b1000 || a_if.out_data !== 8'h41 || a_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL switch_a: valid=%b data=%h in_ready=%b expected 1000/41/1",
                     a_if.out_valid, a_if.out_data, a_if.in_ready);
        end
        drive_a(1'b1, 2'd0, 8'h42, 1'b1);
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0001 || a_if.out_data !== 8'h42 || a_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL switch_b: valid=%b data=%h in_ready=%b expected 0001/42/1",
                     a_if.out_valid, a_if.out_data, a_if.in_ready);
        end
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();
        vectors++;
        if (a_if.out_valid !== 4'b0000 || drop_a !== 8'd0) begin
            errors++;
            $display("FAIL switch_idle: valid=%b drop=%0d expected 0000/0", a_if.out_valid, drop_a);
        end
    endtask

    task automatic test_drop();
        logic [1:0] sels [2];
        sels[0] = 2'd3; sels[1] = 2'd0;
        for (int i = 0; i < 2; i++) begin
            drive_b(1'b1, sels[i], 8'(8'h50 + i), (i == 1));
            #1;
            vectors++;
            if (b_if.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL drop_ready%0d: in_ready=%b expected 1", i, b_if.in_ready);
            end
            cyc();
            vectors++;
            if (b_if.out_valid !== 3'b000) begin
                errors++;
                $display("FAIL drop_valid%0d: valid=%b expected 000", i, b_if.out_valid);
            end
        end
        vectors++;
        if (drop_b !== 8'd2) begin
            errors++;
            $display("FAIL drop_count: drop=%0d expected 2", drop_b);
        end
        drive_b(1'b1, 2'd0, 8'h52, 1'b1);
        cyc();
        vectors++;
        if (b_if.out_valid !== 3'b001 || b_if.out_data !== 8'h52) begin
            errors++;
            $display("FAIL drop_recover: valid=%b data=%h expected 001/52", b_if.out_valid, b_if.out_data);
        end
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();
    endtask

    task automatic test_saturation();
        drive_b(1'b1, 2'd3, 8'h77, 1'b1);
        for (int i = 0; i < 100; i++) cyc();
        vectors++;
        if (drop_b !== 8'd102) begin
            errors++;
            $display("FAIL sat_mid: drop=%0d expected 102", drop_b);
        end
        for (int i = 0; i < 200; i++) cyc();
        vectors++;
        if (drop_b !== 8'd255 || b_if.out_valid !== 3'b000) begin
            errors++;
            $display("FAIL sat_end: drop=%0d valid=%b expected 255/000", drop_b, b_if.out_valid);
        end
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);
        cyc();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        a_if.out_ready = 4'b1111;
        b_if.out_ready = 3'b111;
        drive_a(1'b0, 2'd0, 8'h00, 1'b0);
        drive_b(1'b0, 2'd0, 8'h00, 1'b0);
        test_reset();
        test_packet_lock();
        test_back_pressure();
        test_stream_switch();
        test_drop();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer: the distribution counterpart of the datapath selection muxes.
- Takes one valid/ready beat stream and steers each packet to one of NUM_OUT destination ports, chosen by a select field sampled on the packet's first beat.
- One output register stage; full throughput (1 beat/cycle) while the chosen destination is ready.
- Sits between a shared result/issue source and multiple consumer units.

Parameters:
- DATA_W, 8: beat payload width.
- NUM_OUT, 4: number of destination ports (2..2^SEL_W).
- SEL_W, 2: width of select field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  DATA_W  input beat payload.
- in_last  input  1  final beat of packet.
- in_sel  input  SEL_W  destination index; sampled only on first beat of a packet.
- out_valid  output  NUM_OUT  one-hot per-destination valid.
- out_ready  input  NUM_OUT  per-destination ready.
- out_data  output  DATA_W  payload, shared by all destinations.
- out_last  output  1  last flag, shared.
- drop_cnt  output  8  saturating count of dropped beats.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_last=0, drop_cnt=0, state=IDLE, holding register empty. A reset in the middle of a packet discards the held beat and the packet lock.
- Holding register: hold_valid, hold_data, hold_last, hold_dst.
- out_valid[i] = hold_valid && (hold_dst==i). out_data and out_last drive hold_data and hold_last directly.
- in_ready = !hold_valid || out_ready[hold_dst]. This is combinational from out_ready; there is no path from in_valid to in_ready.
- Accept condition: in_valid && in_ready.
- Drain condition: hold_valid && out_ready[hold_dst].
- Destination of an accepted beat:
  - state IDLE: dst = in_sel.
  - state PKT: dst = lock_sel. in_sel is ignored.
- On accept with dst < NUM_OUT: load the holding register (hold_valid=1). Simultaneous drain and accept in the same cycle is allowed, so throughput is 1 beat/cycle with no bubble.
- On accept with dst >= NUM_OUT:
  - The beat is consumed but not loaded.
  - drop_cnt increments, saturating at 255.
  - If a drain happens in the same cycle, hold_valid clears.
- On drain without accept: hold_valid clears next cycle.
- State machine (advances only on accepted beats, including dropped beats):
  - IDLE + accepted beat with !in_last -> PKT. lock_sel <= in_sel.
  - IDLE + accepted beat with in_last -> stay IDLE (single-beat packet).
  - PKT + accepted beat with in_last -> IDLE.
  - PKT + accepted beat with !in_last -> stay PKT.
- An out-of-range first beat locks an invalid select, so every beat of that packet is dropped.
- Latency: an accepted beat appears on out_* the next cycle.
- Back-pressure: a held beat stays stable until drained. Only the addressed destination's ready matters; out_ready of other ports is ignored.
- Consecutive packets to different destinations: the next packet's first beat may be accepted in the same cycle the previous last beat drains. out_valid then switches one-hot position without a gap.
- in_sel, in_data and in_last are don't-care when in_valid=0.

Test Plan:
- Reset then idle: assert reset mid-cycle with in_valid=1 -> out_valid=0, drop_cnt=0 immediately (asynchronous). After release, a 1-beat packet sel=2, data=0x5A, last=1 -> out_valid=4'b0100, out_data=0x5A the next cycle.
- Packet lock: 3-beat packet with first-beat sel=1, later beats driving in_sel=3, data 0x10/0x11/0x12, all out_ready=1 -> all three on port 1 (out_valid=4'b0010) in consecutive cycles, last on 0x12. State returns to IDLE.
- Back-pressure: out_ready[0]=0 for 3 cycles with a 2-beat packet to port 0 -> in_ready=0 while held. First beat is held stable. When ready rises, the beats emerge back-to-back with no loss or duplication.
- Streaming switch: packet A (1 beat, port 3) followed immediately by packet B (1 beat, port 0) with ready high -> out_valid 4'b1000 then 4'b0001 on consecutive cycles, in_ready stays 1.
- Drop (NUM_OUT=3): 2-beat packet with sel=3 -> no out_valid ever asserted, in_ready=1, drop_cnt=2. A following packet with sel=0 is delivered normally.
- Saturation: 300 dropped single-beat packets -> drop_cnt stops at 255.
